// File: rtl/md_unit_if.sv
// Handshake and result bus between the controller/datapath and the multiply/divide unit.
// The controller drives the request side; the unit drives busy and the HI/LO contents.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, A, B, input busy, hi, lo);
  modport slave  (input start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at the start edge,
// held in res_hi/res_lo, and committed to HI/LO only when the busy countdown expires.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] res_hi_reg, res_hi_next;
  logic [WIDTH-1:0] res_lo_reg, res_lo_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             busy_reg, busy_next;

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   calc_hi, calc_lo;

  // Result of the requested operation on the current operands.
  always_comb begin
    prod_s  = $signed({{WIDTH{bus.A[WIDTH-1]}}, bus.A}) * $signed({{WIDTH{bus.B[WIDTH-1]}}, bus.B});
    prod_u  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
    calc_hi = '0;
    calc_lo = '0;
    case (bus.op)
      3'd0: {calc_hi, calc_lo} = prod_s;
      3'd1: {calc_hi, calc_lo} = prod_u;
      3'd2: begin
        if (bus.B == '0) begin
          calc_hi = bus.A;
          calc_lo = ALL_ONES;
        end else if (bus.A == MOST_NEG && bus.B == ALL_ONES) begin
          // Quotient is unrepresentable; wrap to the dividend with zero remainder.
          calc_hi = '0;
          calc_lo = bus.A;
        end else begin
          calc_lo = $signed(bus.A) / $signed(bus.B);
          calc_hi = $signed(bus.A) % $signed(bus.B);
        end
      end
      3'd3: begin
        if (bus.B == '0) begin
          calc_hi = bus.A;
          calc_lo = ALL_ONES;
        end else begin
          calc_lo = bus.A / bus.B;
          calc_hi = bus.A % bus.B;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    res_hi_next = res_hi_reg;
    res_lo_next = res_lo_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              res_hi_next = calc_hi;
              res_lo_next = calc_lo;
              cnt_next    = bus.op[1] ? 8'(DIV_CYCLES) : 8'(MUL_CYCLES);
              busy_next   = 1'b1;
              state_next  = RUN;
            end
            3'd4:    hi_next = bus.A;
            3'd5:    lo_next = bus.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Requests are ignored here; the controller is expected to stall on busy.
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) begin
          hi_next    = res_hi_reg;
          lo_next    = res_lo_reg;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      hi_reg     <= '0;
      lo_reg     <= '0;
      res_hi_reg <= '0;
      res_lo_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      res_hi_reg <= res_hi_next;
      res_lo_reg <= res_lo_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random operations, compared
// against an arithmetic reference model computed with 64-bit integers.
module tb_md_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) bus ();
  md_unit_if #(.WIDTH(16)) bus16 ();

  md_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  md_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(rst), .bus(bus16)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;
  logic [15:0] m16_hi, m16_lo;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} for an arithmetic op on w-bit operands (results in the low w bits).
  function automatic logic [63:0] ref_calc(input int w, input logic [2:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ua, ub, p, hi64, lo64;
    longint sa, sb;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = longint'(ua << (64 - w)) >>> (64 - w);
    sb   = longint'(ub << (64 - w)) >>> (64 - w);
    hi64 = '0;
    lo64 = '0;
    case (op)
      3'd0, 3'd1: begin
        p    = (op == 3'd0) ? 64'(sa * sb) : ua * ub;
        hi64 = (p >> w) & mask;
        lo64 = p & mask;
      end
      default: begin
        if (ub == 64'd0) begin
          hi64 = ua;
          lo64 = mask;
        end else if (op == 3'd2) begin
          lo64 = 64'(sa / sb) & mask;
          hi64 = 64'(sa % sb) & mask;
        end else begin
          lo64 = ua / ub;
          hi64 = ua % ub;
        end
      end
    endcase
    return {hi64[31:0], lo64[31:0]};
  endfunction

  // Called at a negedge; the request is sampled on the following rising edge.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit intrude);
    logic [63:0] e;
    int n;
    bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.start = intrude; bus.op = 3'd4; bus.A = $urandom; bus.B = $urandom;
    if (op <= 3'd3) begin
      e = ref_calc(32, op, a, b);
      check_val("hold_hi", bus.hi, m_hi);
      check_val("hold_lo", bus.lo, m_lo);
      n = 0;
      while (bus.busy && n < 300) begin
        n++;
        @(negedge clk);
        bus.A  = $urandom;
        bus.op = n[0] ? 3'd0 : 3'd4;
      end
      bus.start = 1'b0;
      check_val("latency", n, op[1] ? 32'd10 : 32'd5);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end else begin
      bus.start = 1'b0;
      check_val("no_busy", 32'(bus.busy), 32'd0);
      if (op == 3'd4) m_hi = a;
      else if (op == 3'd5) m_lo = a;
    end
    check_val("hi", bus.hi, m_hi);
    check_val("lo", bus.lo, m_lo);
    $display("[TB] op=%0d A=%h B=%h intrude=%0d -> hi=%h lo=%h", op, a, b, intrude, bus.hi, bus.lo);
  endtask

  task automatic do16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] e;
    int n;
    bus16.start = 1'b1; bus16.op = op; bus16.A = a; bus16.B = b;
    @(negedge clk);
    bus16.start = 1'b0;
    e = ref_calc(16, op, {16'd0, a}, {16'd0, b});
    n = 0;
    while (bus16.busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check_val("latency16", n, op[1] ? 32'd3 : 32'd1);
    m16_hi = e[47:32];
    m16_lo = e[15:0];
    check_val("hi16", 32'(bus16.hi), 32'(m16_hi));
    check_val("lo16", 32'(bus16.lo), 32'(m16_lo));
    $display("[TB] w16 op=%0d A=%h B=%h -> hi=%h lo=%h", op, a, b, bus16.hi, bus16.lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    bus16.start = 1'b0; bus16.op = '0; bus16.A = '0; bus16.B = '0;
    m_hi = '0; m_lo = '0; m16_hi = '0; m16_lo = '0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_hi", bus.hi, 32'd0);
    check_val("rst_lo", bus.lo, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    check_val("tp_mult_hi", bus.hi, 32'hFFFFFFFF);
    check_val("tp_mult_lo", bus.lo, 32'hFFFFFFFA);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_val("tp_multu_hi", bus.hi, 32'hFFFFFFFE);
    do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check_val("tp_div_lo", bus.lo, 32'hFFFFFFFD);
    do_op(3'd3, 32'd7, 32'd2, 1'b0);
    do_op(3'd2, 32'd5, 32'd0, 1'b0);
    check_val("tp_div0_lo", bus.lo, 32'hFFFFFFFF);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_val("tp_ovf_lo", bus.lo, 32'h80000000);
    do_op(3'd3, 32'd1000, 32'd33, 1'b1);
    do_op(3'd4, 32'h1234, 32'd0, 1'b0);
    do_op(3'd6, 32'hDEADBEEF, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
      do_op(rop, ra, rb, (rop <= 3'd3) && ($urandom_range(0, 3) == 0));
    end

    do16(3'd0, 16'h8000, 16'h8000);
    check_val("tp_w16_hi", 32'(bus16.hi), 32'h4000);
    do16(3'd0, 16'($urandom), 16'($urandom));
    do16(3'd2, 16'h8000, 16'hFFFF);
    do16(3'd3, 16'($urandom), 16'($urandom_range(1, 255)));

    // Abort a divide three cycles in; reset must clear outputs before the next edge.
    do_op(3'd4, 32'hCAFE0001, 32'd0, 1'b0);
    do_op(3'd5, 32'hBEEF0002, 32'd0, 1'b0);
    bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_hi", bus.hi, 32'd0);
    check_val("abort_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m16_hi = '0; m16_lo = '0;
    repeat (12) @(negedge clk);
    check_val("post_abort_busy", 32'(bus.busy), 32'd0);
    check_val("post_abort_hi", bus.hi, m_hi);
    check_val("post_abort_lo", bus.lo, m_lo);
    $display("[TB] abort: hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);
    do_op(3'd3, 32'd7, 32'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
